// File: rtl/spi_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : spi_master_arbiter
// Description : Round-robin arbitrated SPI mode-0 master. Grants one of N_REQ
//               requesters, shifts its DATA_W-bit word out MSB-first on mosi
//               under a generated sclk/ss and captures the returned word.
//               Optional build macro: SPI_MASTER_LOOPBACK_EN (rx shift
//               register samples the internal mosi register, miso ignored).
// Revision    : 1.0 - initial release
// ============================================================================
module spi_master_arbiter #(
    parameter int DATA_W  = 4,
    parameter int CLK_DIV = 4,
    parameter int N_REQ   = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          gnt,
    output logic                      busy,
    output logic                      done,
    output logic [DATA_W-1:0]         rx_data,
    output logic                      sclk,
    output logic                      ss,
    output logic                      mosi,
    input  logic                      miso
);

    localparam int c_PH_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int c_BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int c_IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [c_PH_W-1:0]  c_PH_LAST  = c_PH_W'(CLK_DIV - 1);
    localparam logic [c_BIT_W-1:0] c_BIT_LAST = c_BIT_W'(DATA_W - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(N_REQ - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_SCK_HI = 3'd2,
        ST_SCK_LO = 3'd3,
        ST_HOLD   = 3'd4
    } state_t;

    // Registered state
    state_t               r_state;
    logic [c_PH_W-1:0]    r_phase;
    logic [c_BIT_W-1:0]   r_bit;
    logic [DATA_W-1:0]    r_tx_sr;
    logic [DATA_W-1:0]    r_rx_sr;
    logic [c_IDX_W-1:0]   r_rr_ptr;
    logic [N_REQ-1:0]     r_gnt;
    logic                 r_busy;
    logic                 r_done;
    logic [DATA_W-1:0]    r_rx_data;
    logic                 r_sclk;
    logic                 r_ss;
    logic                 r_mosi;

    // Next-state values
    state_t               w_state_next;
    logic [c_PH_W-1:0]    w_phase_next;
    logic [c_BIT_W-1:0]   w_bit_next;
    logic [DATA_W-1:0]    w_tx_next;
    logic [DATA_W-1:0]    w_rx_next;
    logic [c_IDX_W-1:0]   w_ptr_next;
    logic [N_REQ-1:0]     w_gnt_next;
    logic                 w_done_next;
    logic [DATA_W-1:0]    w_rx_data_next;

    // Arbitration results
    logic                 w_any;
    logic [c_IDX_W-1:0]   w_sel;
    int                   v_idx;

    logic                 w_ph_last;
    logic                 w_grant_ok;
    logic                 w_rx_bit;

`ifdef SPI_MASTER_LOOPBACK_EN
    assign w_rx_bit = r_mosi;
`else
    assign w_rx_bit = miso;
`endif

    assign w_ph_last = (r_phase == c_PH_LAST);

    // Round-robin search: first set request at or after rr_ptr, wrapping.
    // Walk offsets from highest to lowest so the smallest offset wins.
    always_comb begin
        w_any = 1'b0;
        w_sel = '0;
        v_idx = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            v_idx = int'(r_rr_ptr) + k;
            if (v_idx >= N_REQ) begin
                v_idx = v_idx - N_REQ;
            end
            if (req[v_idx[c_IDX_W-1:0]]) begin
                w_any = 1'b1;
                w_sel = v_idx[c_IDX_W-1:0];
            end
        end
    end

    // Next-state, datapath and grant logic
    always_comb begin
        w_state_next   = r_state;
        w_phase_next   = r_phase;
        w_bit_next     = r_bit;
        w_tx_next      = r_tx_sr;
        w_rx_next      = r_rx_sr;
        w_ptr_next     = r_rr_ptr;
        w_gnt_next     = '0;
        w_grant_ok     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // The grant cycle itself is spent in IDLE; move on once
                // the pulse has been presented.
                if (r_gnt != '0) begin
                    w_state_next = ST_SETUP;
                    w_phase_next = '0;
                end else begin
                    w_grant_ok = 1'b1;
                end
            end
            ST_SETUP: begin
                if (w_ph_last) begin
                    w_state_next = ST_SCK_HI;
                    w_phase_next = '0;
                    w_rx_next    = {r_rx_sr[DATA_W-2:0], w_rx_bit};
                end else begin
                    w_phase_next = r_phase + 1'b1;
                end
            end
            ST_SCK_HI: begin
                if (w_ph_last) begin
                    w_phase_next = '0;
                    if (r_bit == c_BIT_LAST) begin
                        w_state_next = ST_HOLD;
                    end else begin
                        w_state_next = ST_SCK_LO;
                        w_tx_next    = {r_tx_sr[DATA_W-2:0], 1'b0};
                        w_bit_next   = r_bit + 1'b1;
                    end
                end else begin
                    w_phase_next = r_phase + 1'b1;
                end
            end
            ST_SCK_LO: begin
                if (w_ph_last) begin
                    w_state_next = ST_SCK_HI;
                    w_phase_next = '0;
                    w_rx_next    = {r_rx_sr[DATA_W-2:0], w_rx_bit};
                end else begin
                    w_phase_next = r_phase + 1'b1;
                end
            end
            ST_HOLD: begin
                if (w_ph_last) begin
                    // Leaving HOLD lands in IDLE, so a waiting requester may be
                    // granted on this same edge (ss high for one cycle).
                    w_state_next = ST_IDLE;
                    w_phase_next = '0;
                    w_grant_ok   = 1'b1;
                end else begin
                    w_phase_next = r_phase + 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_phase_next = '0;
            end
        endcase

        if (w_grant_ok && w_any) begin
            w_gnt_next = N_REQ'(1) << w_sel;
            w_tx_next  = req_data[w_sel*DATA_W +: DATA_W];
            w_bit_next = '0;
            w_ptr_next = (w_sel == c_IDX_LAST) ? '0 : w_sel + 1'b1;
        end

        w_done_next    = (w_state_next == ST_HOLD) && (w_phase_next == c_PH_LAST);
        w_rx_data_next = w_done_next ? r_rx_sr : r_rx_data;
    end

    // State and output registers; outputs track the state they belong to
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_phase   <= '0;
            r_bit     <= '0;
            r_tx_sr   <= '0;
            r_rx_sr   <= '0;
            r_rr_ptr  <= '0;
            r_gnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_rx_data <= '0;
            r_sclk    <= 1'b0;
            r_ss      <= 1'b1;
            r_mosi    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_phase   <= w_phase_next;
            r_bit     <= w_bit_next;
            r_tx_sr   <= w_tx_next;
            r_rx_sr   <= w_rx_next;
            r_rr_ptr  <= w_ptr_next;
            r_gnt     <= w_gnt_next;
            r_busy    <= (w_state_next != ST_IDLE);
            r_done    <= w_done_next;
            r_rx_data <= w_rx_data_next;
            r_sclk    <= (w_state_next == ST_SCK_HI);
            r_ss      <= (w_state_next == ST_IDLE);
            r_mosi    <= (w_state_next == ST_IDLE) ? 1'b0 : w_tx_next[DATA_W-1];
        end
    end

    assign gnt     = r_gnt;
    assign busy    = r_busy;
    assign done    = r_done;
    assign rx_data = r_rx_data;
    assign sclk    = r_sclk;
    assign ss      = r_ss;
    assign mosi    = r_mosi;

endmodule
`default_nettype wire

// File: doc/spi_master_arbiter.md
# spi_master_arbiter

SPI master that sequences 4-bit transfers to the SPI slave driving the 7-segment display and PWM. Arbitrates round-robin between N_REQ requesters and serializes the granted word MSB-first on mosi under a generated sclk/ss. Captures the word returned on miso. Sits between the control logic (buttons/FSMs) and the off-chip or on-board slave.

## Interface
- DATA_W, 4: bits per transfer.
- CLK_DIV, 4: clk cycles per sclk half-period; legal ≥1.
- N_REQ, 2: number of requesters; legal 2..8.

- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- req  in  N_REQ  per-requester transfer request, level-sensitive.
- req_data  in  N_REQ*DATA_W  requester i word at [i*DATA_W +: DATA_W].
- gnt  out  N_REQ  one-hot, one-cycle pulse when a request is accepted.
- busy  out  1  high while a transfer is in progress.
- done  out  1  one-cycle pulse on the last cycle of a transfer.
- rx_data  out  DATA_W  word received on miso; valid from done, held until the next done.
- sclk  out  1  SPI clock, idle low (mode 0).
- ss  out  1  slave select, active-low.
- mosi  out  1  serial data to slave.
- miso  in  1  serial data from slave.

## Operation
- FSM states: IDLE, SETUP, SCK_HI, SCK_LO, HOLD. A phase counter counts CLK_DIV cycles per state, except IDLE. A bit counter counts 0..DATA_W-1.
- IDLE: ss=1, sclk=0, busy=0.
  - If any req bit is set, grant the first set bit at or after rr_ptr, searching upward with wrap.
  - On a grant: pulse gnt, latch that requester's req_data into tx_sr, set rr_ptr to granted index+1 (mod N_REQ), go to SETUP.
- SETUP, CLK_DIV cycles: ss=0, sclk=0, mosi=tx_sr MSB. Then go to SCK_HI.
- SCK_HI, CLK_DIV cycles: sclk=1.
  - On entry: rx_sr <= {rx_sr[DATA_W-2:0], miso}.
  - At exit: if the bit counter equals DATA_W-1, go to HOLD; otherwise go to SCK_LO.
- SCK_LO, CLK_DIV cycles: sclk=0.
  - On entry: shift tx_sr left, so mosi presents the next bit, and increment the bit counter.
  - At exit, go to SCK_HI.
- HOLD, CLK_DIV cycles: sclk=0, ss=0. On the last cycle: done=1 and rx_data <= rx_sr. Then go to IDLE.
- mosi changes only while sclk is low. The slave samples on the sclk rising edge.
- Requests are not queued. A requester keeps req high until it sees its gnt. req_data is sampled only in the grant cycle.
- Deasserting req after gnt has no effect on the current transfer.
- rr_ptr reset value: 0. After reset, requester 0 wins a tie.

## Timing
- Grant in cycle T (IDLE). busy=1 and ss=0 in cycles T+1 .. T+(2*DATA_W+1)*CLK_DIV.
- done pulses in the last of those cycles. Defaults: T+36.
- ss returns to 1 in the following cycle. The earliest next gnt is in that same cycle, so ss is high for at least 1 cycle between back-to-back transfers.
- All outputs are registered.
- Reset values: gnt=0, busy=0, done=0, rx_data=0, sclk=0, ss=1, mosi=0. FSM=IDLE, counters=0, rr_ptr=0.
- Reset mid-transfer: on the next edge ss=1 and sclk=0, with no done pulse. rx_data is cleared to 0. The aborted requester must re-request.
- req changing during a transfer is ignored until IDLE.

## Configuration
- SPI_MASTER_LOOPBACK_EN defined: rx_sr samples the internal mosi register instead of the miso pin. After each transfer, rx_data equals the transmitted word. The miso pin is unused. Used for board bring-up without a slave.
- Not defined: rx_sr samples miso as specified above.

## Test plan
- Single transfer: req=2'b01, req_data[3:0]=4'hA, miso driven 0,1,0,1 on successive sclk rising edges -> gnt=2'b01 at T. mosi=1,0,1,0 at the four sclk rises. sclk has 4 high pulses of 4 cycles each. done at T+36, rx_data=4'h5. ss high at T+37.
- Tie after reset: req=2'b11 held, words 4'h3 and 4'hC -> grants alternate 01,10,01,10. mosi words are 3,C,3,C. ss is high exactly 1 cycle between transfers.
- Back-to-back: req=2'b10 held, 4'hF -> a new gnt arrives in each cycle immediately after done+1. No done is lost.
- Reset mid-transfer: rst asserted 1 cycle during the 2nd SCK_HI -> the next cycle has ss=1, sclk=0, busy=0, rx_data=0, and no done. A subsequent req=2'b01 completes normally.
- CLK_DIV=1, DATA_W=4 -> done at T+9. sclk toggles every cycle.
- SPI_MASTER_LOOPBACK_EN build, miso tied 0 -> transmit 4'h6, rx_data=4'h6 at done.
